multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the 16-bit lab CPU. Owns the program counter and instruction register, fetches instructions over a request/acknowledge instruction-memory port, and presents the latched instruction to the combinational decoder. Consumes the decoder's control fields to step each instruction through fetch, decode, execute, optional memory and write-back. Pulses register-file and data-memory strobes, resolves branches and stops cleanly on HALT.

## Interface
- PC_W, 8: program-counter width; word-addressed, one 16-bit instruction per address.
- RESET_PC, 0: PC value loaded on reset.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- IMEM_REQ  out  1  fetch request; held until acknowledged.
- IMEM_ADDR  out  PC_W  fetch address; equals PC.
- IMEM_ACK  in  1  fetch data valid this cycle.
- IMEM_DATA  in  16  fetched instruction.
- INST  out  16  instruction register; drives the decoder.
- LD_IN, MD_IN, MW_IN, HALT_IN  in  1 each  decoder control fields.
- BS_IN  in  3  decoder branch select.
- OFF_IN  in  6  decoder branch offset; two's complement.
- ZERO, NEG  in  1 each  ALU result flags.
- DMEM_REQ  out  1  data-memory request; held until acknowledged.
- DMEM_WE  out  1  data-memory write; valid with DMEM_REQ.
- DMEM_ACK  in  1  data access complete.
- RF_WE  out  1  register-file write strobe; one-cycle pulse.
- PC  out  PC_W  current program counter.
- HALTED  out  1  processor stopped.
- STATE  out  3  current state code, for debug.
- RETIRED  out  16  count of retired non-HALT instructions; wraps.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5. Codes 6 and 7 are unreachable and return to FETCH.
- **Reset** (asynchronous): state=FETCH, PC=RESET_PC, INST=0, flags=0, RETIRED=0, HALTED=0; all strobes low.
- **FETCH**: IMEM_REQ=1 with IMEM_ADDR=PC. On the edge where IMEM_ACK=1: INST<=IMEM_DATA, go to DECODE. An acknowledge in the same cycle as the first request is legal (zero wait states).
- **DECODE**: one cycle; decoder outputs settle from INST.
  - If HALT_IN=1: go to HALTED; PC and RETIRED unchanged.
  - Otherwise: go to EXEC.
- **EXEC**: one cycle. Latch ZERO and NEG into flag registers.
  - If MW_IN or (LD_IN and MD_IN): go to MEM.
  - Otherwise: go to WB.
- **MEM**: DMEM_REQ=1 and DMEM_WE=MW_IN, held until DMEM_ACK=1; then go to WB.
- **WB**: one cycle; go to FETCH.
  - RF_WE=LD_IN.
  - RETIRED+=1.
  - PC update:
    - Branch taken: PC <= PC+1+sext(OFF_IN).
    - Otherwise: PC <= PC+1.
    - Arithmetic is modulo 2^PC_W.
- **HALTED**: HALTED=1, all strobes 0. Held until reset.
- **Branch codes (BS_IN)**, evaluated on the latched flags:
  - 000 none.
  - 001 taken if Z=1.
  - 010 taken if Z=0.
  - 011 taken if N=0.
  - 100 taken if N=1.
  - 101 always taken.
  - 110 and 111: not taken.
- NOP (all-zero instruction): passes EXEC and WB with RF_WE=0; PC+1; counts as retired.
- IMEM_ACK outside FETCH and DMEM_ACK outside MEM: ignored.

## Timing
- Cycles per instruction with zero-wait memories:
  - 4 for ALU ops, NOP and branches (FETCH, DECODE, EXEC, WB).
  - 5 for load and store.
  - Each memory wait cycle adds one.
- INST changes only on the FETCH-acknowledge edge; decoder inputs are stable from DECODE through WB.
- RF_WE asserts in exactly one cycle per instruction, the WB cycle. DMEM_REQ is never asserted outside MEM.
- PC update and RETIRED increment occur on the WB-exit edge. PC is stable during FETCH.
- Reset asserted mid-FETCH or mid-MEM: the request drops immediately and asynchronously. A late acknowledge after reset release, while in FETCH, is accepted as the response at RESET_PC.
- RETIRED wraps from 0xFFFF to 0x0000.

## Structure
- Shared package ctrl_pkg holds:
  - state codes;
  - BS codes;
  - reset constants: RESET_PC default and INST reset value 0.
- Sub-module pc_next: combinational next-PC from PC, BS, OFF and the latched flags. Reused by any future pipelined variant.
- The FSM, PC, IR, flag registers and retire counter live in multicycle_ctrl.

## Test plan
- ADDI 0x5283 (LD_IN=1, MD=MW=0), zero-wait fetch -> RF_WE pulses in cycle 4 only; PC 0->1; RETIRED=1.
- LB 0x2283 with DMEM_ACK delayed 2 cycles -> DMEM_REQ high 3 cycles, DMEM_WE=0; RF_WE in cycle 7; PC=1.
- Store (MW_IN=1) -> DMEM_WE=1 throughout MEM; RF_WE never asserts.
- BS=001 with ZERO=1 in EXEC, OFF=6'b111110 (-2) at PC=5 -> PC=4. Same instruction with ZERO=0 -> PC=6.
- Instruction 0x0001 (HALT_IN=1) -> HALTED=1 after DECODE; no further IMEM_REQ; PC and RETIRED frozen.
- RST_N low while IMEM_REQ is waiting at PC=9 -> IMEM_REQ low in the same cycle; after release, fetch resumes at PC=RESET_PC with all outputs at reset values.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state codes,
// branch-select codes, reset constants and the branch-condition helper.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  localparam logic [2:0] BS_NONE   = 3'b000;
  localparam logic [2:0] BS_Z      = 3'b001;
  localparam logic [2:0] BS_NZ     = 3'b010;
  localparam logic [2:0] BS_NN     = 3'b011;
  localparam logic [2:0] BS_N      = 3'b100;
  localparam logic [2:0] BS_ALWAYS = 3'b101;

  localparam int          RESET_PC_DEFAULT = 0;
  localparam logic [15:0] INST_RESET       = 16'h0000;

  // Codes 110 and 111 are reserved and never take the branch.
  function automatic logic branch_taken(input logic [2:0] bs, input logic z, input logic n);
    logic taken;
    case (bs)
      BS_Z:      taken = z;
      BS_NZ:     taken = !z;
      BS_NN:     taken = !n;
      BS_N:      taken = n;
      BS_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_pc_next.sv
// Combinational next-PC: PC+1, plus the sign-extended offset when the
// selected branch condition holds on the latched flags.
module pc_next
  import ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      bs,
  input  logic [5:0]      off,
  input  logic            z,
  input  logic            n,
  output logic [PC_W-1:0] pc_nxt
);

  logic [PC_W-1:0] off_ext;

  always_comb begin
    off_ext = PC_W'(signed'(off));
    pc_nxt  = pc + PC_W'(1);
    if (branch_taken(bs, z, n)) begin
      pc_nxt = pc_nxt + off_ext;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: owns PC, IR, ALU flags and the retire
// counter, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     inst,
  input  logic            ld_in,
  input  logic            md_in,
  input  logic            mw_in,
  input  logic            halt_in,
  input  logic [2:0]      bs_in,
  input  logic [5:0]      off_in,
  input  logic            zero,
  input  logic            neg,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [2:0]      state,
  output logic [15:0]     retired
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
  logic [15:0]     inst_q, inst_d;
  logic [15:0]     retired_q, retired_d;
  logic            z_q, z_d, n_q, n_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic            rf_we_q, rf_we_d;
  logic            halted_q, halted_d;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc     (pc_q),
    .bs     (bs_in),
    .off    (off_in),
    .z      (z_q),
    .n      (n_q),
    .pc_nxt (pc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    z_d       = z_q;
    n_d       = n_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = halt_in ? ST_HALTED : ST_EXEC;
      ST_EXEC: begin
        z_d     = zero;
        n_d     = neg;
        state_d = (mw_in || (ld_in && md_in)) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        pc_d      = pc_nxt;
        retired_d = retired_q + 16'd1;
        state_d   = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase

    // Outputs are registered from the next state so they are glitch-free
    // and still drop asynchronously with reset.
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) && mw_in;
    rf_we_d    = (state_d == ST_WB) && ld_in;
    halted_d   = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= INST_RESET;
      retired_q  <= 16'd0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      retired_q  <= retired_d;
      z_q        <= z_d;
      n_q        <= n_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign rf_we     = rf_we_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a small decoder model and memory
// responders drive the DUT; a monitor checks each retired instruction.
module tb_multicycle_ctrl;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [15:0]     inst;
  logic            ld_in, md_in, mw_in, halt_in;
  logic [2:0]      bs_in;
  logic [5:0]      off_in;
  logic            zero, neg;
  logic            dmem_req, dmem_we, dmem_ack;
  logic            rf_we;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [2:0]      state;
  logic [15:0]     retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.PC_W(PC_W), .RESET_PC(8'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .inst      (inst),
    .ld_in     (ld_in),
    .md_in     (md_in),
    .mw_in     (mw_in),
    .halt_in   (halt_in),
    .bs_in     (bs_in),
    .off_in    (off_in),
    .zero      (zero),
    .neg       (neg),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_we     (rf_we),
    .pc        (pc),
    .halted    (halted),
    .state     (state),
    .retired   (retired)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decoder and ALU-flag model keyed on the latched instruction word.
  int dwait;
  always_comb begin
    ld_in = 1'b0; md_in = 1'b0; mw_in = 1'b0; halt_in = 1'b0;
    bs_in = 3'b000; off_in = 6'd0; zero = 1'b0; neg = 1'b0; dwait = 0;
    case (inst)
      16'h5283: ld_in = 1'b1;
      16'h2283: begin ld_in = 1'b1; md_in = 1'b1; dwait = 2; end
      16'h3283: begin mw_in = 1'b1; dwait = 1; end
      16'h0001: halt_in = 1'b1;
      16'hA041: begin bs_in = 3'b101; off_in = 6'd1; end
      16'hA0C5: begin bs_in = 3'b101; off_in = 6'd5; end
      16'h8F3E: begin bs_in = 3'b001; off_in = 6'b111110; zero = 1'b1; end
      16'h8E3E: begin bs_in = 3'b001; off_in = 6'b111110; zero = 1'b0; end
      16'h9003: begin bs_in = 3'b010; off_in = 6'd3; zero = 1'b0; end
      16'hB001: begin bs_in = 3'b011; off_in = 6'd1; neg = 1'b1; end
      16'hC002: begin bs_in = 3'b100; off_in = 6'd2; neg = 1'b1; end
      16'hD005: begin bs_in = 3'b110; off_in = 6'd5; zero = 1'b1; neg = 1'b1; end
      default: ;
    endcase
  end

  // Instruction memory responder.
  logic [15:0] imem [256];
  logic        imem_ack_r = 1'b0;
  logic        late_ack   = 1'b0;
  int          iwait_addr = 2;
  int          stall_addr = -1;
  assign imem_ack  = imem_ack_r | late_ack;
  assign imem_data = imem[imem_addr];

  initial begin
    int icnt;
    icnt = 0;
    forever begin
      @(negedge clk);
      if (imem_req && rst_n && int'(imem_addr) != stall_addr) begin
        if (icnt >= ((int'(imem_addr) == iwait_addr) ? 1 : 0)) imem_ack_r = 1'b1;
        else begin imem_ack_r = 1'b0; icnt++; end
      end else begin
        imem_ack_r = 1'b0;
        icnt = 0;
      end
    end
  end

  // Data memory responder.
  initial begin
    int dcnt;
    dcnt = 0;
    dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dmem_req && rst_n) begin
        if (dcnt >= dwait) dmem_ack = 1'b1;
        else begin dmem_ack = 1'b0; dcnt++; end
      end else begin
        dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
  end

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ret;
    int cyc;
    int rf_at;
    int dreq;
    int dwe;
  } exp_t;
  exp_t exp_q[$];

  function automatic void push(input int p, input int r, input int c, input int rf_at,
                               input int dq, input int dw);
    exp_t e;
    e.pc = 8'(p); e.ret = 16'(r); e.cyc = c; e.rf_at = rf_at; e.dreq = dq; e.dwe = dw;
    exp_q.push_back(e);
  endfunction

  // Monitor: accumulates per-instruction activity, compares on WB exit or HALT entry.
  initial begin
    logic [2:0] prev;
    bit in_inst;
    int cyc, rf, rf_at, dreq, dwe, stray;
    exp_t e;
    prev = 3'd0; in_inst = 1'b0;
    cyc = 0; rf = 0; rf_at = 0; dreq = 0; dwe = 0; stray = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_inst = 1'b0;
        prev = 3'd0;
        continue;
      end
      if (in_inst && ((state == 3'd0 && prev == 3'd4) || (state == 3'd5 && prev != 3'd5))) begin
        in_inst = 1'b0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard_underflow: got retire at pc=%0d, expected none", pc);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] retire -> pc=%0d retired=%0d cycles=%0d rf_we@%0d dmem_req=%0d dmem_we=%0d",
                   pc, retired, cyc, rf_at, dreq, dwe);
          check("pc", int'(pc), int'(e.pc));
          check("retired", int'(retired), int'(e.ret));
          check("cycles", cyc, e.cyc);
          check("rf_we_count", rf, (e.rf_at != 0) ? 1 : 0);
          check("rf_we_cycle", rf_at, e.rf_at);
          check("dmem_req_cycles", dreq, e.dreq);
          check("dmem_we_cycles", dwe, e.dwe);
          check("stray_strobes", stray, 0);
        end
      end
      if (!in_inst && state == 3'd0 && imem_req) begin
        in_inst = 1'b1;
        cyc = 0; rf = 0; rf_at = 0; dreq = 0; dwe = 0; stray = 0;
      end
      if (in_inst) begin
        cyc++;
        if (rf_we) begin rf++; rf_at = cyc; end
        if (dmem_req) dreq++;
        if (dmem_req && dmem_we) dwe++;
        if ((dmem_req && state != 3'd3) || (rf_we && state != 3'd4)) stray++;
      end
      prev = state;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int reqs, rfc;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0]  = 16'h5283; imem[1]  = 16'h2283; imem[2]  = 16'h3283;
    imem[3]  = 16'hA041; imem[4]  = 16'hA0C5; imem[5]  = 16'h8F3E;
    imem[10] = 16'h8E3E; imem[11] = 16'h9003; imem[15] = 16'hB001;
    imem[16] = 16'hC002; imem[19] = 16'hD005; imem[21] = 16'h0001;
    //   pc  ret cyc rf_at dreq dwe
    push(1,  1,  4,  4,   0,   0);   // ADDI
    push(2,  2,  7,  7,   3,   0);   // LB, dmem ack 2 late
    push(3,  3,  7,  0,   2,   2);   // SB, 1 fetch wait + 1 dmem wait
    push(5,  4,  4,  0,   0,   0);   // always +1
    push(4,  5,  4,  0,   0,   0);   // BZ taken, off -2 at pc 5
    push(10, 6,  4,  0,   0,   0);   // always +5
    push(11, 7,  4,  0,   0,   0);   // BZ not taken
    push(15, 8,  4,  0,   0,   0);   // BNZ taken +3
    push(16, 9,  4,  0,   0,   0);   // N=0 cond, N=1: not taken
    push(19, 10, 4,  0,   0,   0);   // N=1 taken +2
    push(20, 11, 4,  0,   0,   0);   // reserved code 110
    push(21, 12, 4,  0,   0,   0);   // NOP
    push(21, 12, 2,  0,   0,   0);   // HALT

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_imem_req", imem_req, 0);
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_inst", inst, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_dmem_req", dmem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 400; k++) begin
      if (halted) break;
      @(negedge clk);
    end
    check("halt_reached", halted, 1);
    reqs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    check("halt_no_fetch", reqs, 0);
    check("halt_pc_frozen", pc, 21);
    check("halt_retired_frozen", retired, 12);
    check("halt_state", state, 5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] program run complete, halted at pc=%0d", pc);

    // Reset while a fetch at pc 9 is outstanding.
    rst_n = 1'b0;
    iwait_addr = -1;
    stall_addr = 9;
    #1;
    check("rst2_halted", halted, 0);
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 1; i <= 9; i++) push(i, i, 4, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (pc == 8'd9 && state == 3'd0) break;
    end
    repeat (2) @(negedge clk);
    check("stall_pc", pc, 9);
    check("stall_imem_req", imem_req, 1);
    check("nop_scoreboard_drained", exp_q.size(), 0);
    imem[0] = 16'h5283;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_imem_req", imem_req, 0);
    check("async_rst_pc", pc, 0);
    check("async_rst_state", state, 0);
    check("async_rst_retired", retired, 0);
    check("async_rst_inst", inst, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_ack = 1'b1;
    stall_addr = -1;
    @(negedge clk);
    late_ack = 1'b0;
    check("late_ack_inst", inst, 16'h5283);
    check("late_ack_state", state, 1);
    check("late_ack_pc", pc, 0);
    rfc = 0;
    for (int k = 0; k < 20; k++) begin
      if (pc == 8'd1) break;
      @(negedge clk);
      if (rf_we) rfc++;
    end
    check("late_ack_pc_next", pc, 1);
    check("late_ack_rf_we", rfc, 1);
    check("late_ack_retired", retired, 1);
    $display("[TB] reset/late-ack sequence complete at pc=%0d", pc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
